mux_rr_arbiter: RTL



---
 rtl/mux_rr_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter that shares one 4:1 mux datapath among
// four valid/ready requesters and captures the winner's word into a one-entry
// registered output stage.
//
// Ports:
//   clk                  clock, rising edge
//   rst_n                asynchronous active-low reset
//   in_valid[3:0]        bit i = requester i has a word
//   in_data0..in_data3   requester payloads, WIDTH bits each
//   in_ready[3:0]        one-hot (or zero) accept strobe back to the requesters
//   out_valid            output word present
//   out_ready            consumer accepts the output word
//   out_data[WIDTH-1:0]  captured word
//   out_src[1:0]         index of the requester that supplied out_data
module mux_rr_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src
);

  // The mux works on 2-bit slices; an odd width gets one zero-padded top slice.
  localparam int unsigned NSlice = (WIDTH + 1) / 2;
  localparam int unsigned PadW   = 2 * NSlice;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_src_q, out_src_d;
  logic [1:0]       last_q, last_d;

  logic             can_accept;
  logic             found;
  logic [1:0]       win;
  logic             accept;
  logic [PadW-1:0]  pad [4];
  logic [PadW-1:0]  sel_pad;

  assign can_accept = ~out_valid_q | out_ready;

  // Scan last+1 .. last+4 (mod 4); the first valid requester wins.
  always_comb begin
    logic [1:0] idx;
    idx   = '0;
    win   = last_q;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && in_valid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Held low during reset so no requester sees a spurious accept.
  assign accept   = can_accept & found & rst_n;
  assign in_ready = accept ? (4'b0001 << win) : 4'b0000;

  always_comb begin
    pad[0] = PadW'(in_data0);
    pad[1] = PadW'(in_data1);
    pad[2] = PadW'(in_data2);
    pad[3] = PadW'(in_data3);
  end

  // Sliced 4:1 mux, select = winner index.
  always_comb begin
    sel_pad = '0;
    for (int s = 0; s < int'(NSlice); s++) begin
      unique case (win)
        2'd0:    sel_pad[2*s +: 2] = pad[0][2*s +: 2];
        2'd1:    sel_pad[2*s +: 2] = pad[1][2*s +: 2];
        2'd2:    sel_pad[2*s +: 2] = pad[2][2*s +: 2];
        default: sel_pad[2*s +: 2] = pad[3][2*s +: 2];
      endcase
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    last_d      = last_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_pad[WIDTH-1:0];
      out_src_d   = win;
      last_d      = win;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 2'd0;
      last_q      <= 2'd3;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      last_q      <= last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule
